// File: rtl/uart_cmd_bridge.sv
// UART byte-stream to register-bus command bridge (read/write, auto-increment or fixed address).
// Optional feature: define UART_CMD_BRIDGE_ACK_EN to send 0xA5 after every completed write command.
module uart_cmd_bridge #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [ADDR_W-1:0] bus2ip_addr_o,
  output logic [DATA_W-1:0] bus2ip_data_o,
  output logic              bus2ip_rd_ce_o,
  output logic              bus2ip_wr_ce_o,
  input  logic [DATA_W-1:0] ip2bus_data_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned ABytes = ADDR_W / 8;
  localparam int unsigned DBytes = DATA_W / 8;
  localparam int unsigned TW     = $clog2(TIMEOUT_CYC + 2);
  localparam logic [1:0]    ALast = 2'(ABytes - 1);
  localparam logic [1:0]    DLast = 2'(DBytes - 1);
  localparam logic [TW-1:0] TLim  = TW'(TIMEOUT_CYC);

  if ((ADDR_W % 8) != 0 || ADDR_W < 8 || ADDR_W > 32) begin : g_bad_addr_w
    $error("ADDR_W must be a multiple of 8 in 8..32");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 32) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8 in 8..32");
  end

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StWrite,
    StRead,
    StRwait,
    StRdata
`ifdef UART_CMD_BRIDGE_ACK_EN
    , StAck
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [3:0]        word_cnt_q, word_cnt_d;
  logic              is_wr_q, is_wr_d;
  logic              fixed_q, fixed_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              timeout_q, timeout_d;

  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] rd_shift;

  assign addr_next = fixed_q ? addr_q : addr_q + ADDR_W'(1);
  // Byte 0 of a word goes out first and is its most significant byte.
  assign rd_shift  = rdata_q >> {(DLast - byte_cnt_q), 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      is_wr_q    <= 1'b0;
      fixed_q    <= 1'b0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      is_wr_q    <= is_wr_d;
      fixed_q    <= fixed_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    is_wr_d    = is_wr_q;
    fixed_d    = fixed_q;
    timer_d    = timer_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid_i) begin
          is_wr_d    = rx_data_i[7];
          fixed_d    = rx_data_i[6];
          word_cnt_d = rx_data_i[3:0];
          byte_cnt_d = '0;
          timer_d    = '0;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (rx_valid_i) begin
          addr_d  = (addr_q << 8) | ADDR_W'(rx_data_i);
          timer_d = '0;
          if (byte_cnt_q == ALast) begin
            byte_cnt_d = '0;
            state_d    = is_wr_q ? StWdata : StRead;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (timer_q >= TLim) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StWdata: begin
        if (rx_valid_i) begin
          wdata_d = (wdata_q << 8) | DATA_W'(rx_data_i);
          timer_d = '0;
          if (byte_cnt_q == DLast) begin
            byte_cnt_d = '0;
            state_d    = StWrite;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (timer_q >= TLim) begin
          // Partial word is discarded; earlier words stay written.
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StWrite: begin
        addr_d = addr_next;
        if (word_cnt_q == 4'd0) begin
`ifdef UART_CMD_BRIDGE_ACK_EN
          state_d = StAck;
`else
          state_d = StIdle;
`endif
        end else begin
          word_cnt_d = word_cnt_q - 4'd1;
          state_d    = StWdata;
        end
      end
      StRead: begin
        state_d = StRwait;
      end
      StRwait: begin
        rdata_d    = ip2bus_data_i;
        byte_cnt_d = '0;
        state_d    = StRdata;
      end
      StRdata: begin
        if (tx_ready_i) begin
          if (byte_cnt_q == DLast) begin
            byte_cnt_d = '0;
            addr_d     = addr_next;
            if (word_cnt_q == 4'd0) begin
              state_d = StIdle;
            end else begin
              word_cnt_d = word_cnt_q - 4'd1;
              state_d    = StRead;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
`ifdef UART_CMD_BRIDGE_ACK_EN
      StAck: begin
        if (tx_ready_i) begin
          state_d = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    if (state_q == StRdata) begin
      tx_valid_o = 1'b1;
      tx_data_o  = rd_shift[7:0];
    end
`ifdef UART_CMD_BRIDGE_ACK_EN
    if (state_q == StAck) begin
      tx_valid_o = 1'b1;
      tx_data_o  = 8'hA5;
    end
`endif
  end

  assign bus2ip_addr_o  = addr_q;
  assign bus2ip_data_o  = wdata_q;
  assign bus2ip_rd_ce_o = (state_q == StRead);
  assign bus2ip_wr_ce_o = (state_q == StWrite);
  assign busy_o         = (state_q != StIdle);
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: table of write commands plus hand-written read,
// timeout and reset sequences, checked against hand-computed expectations.
module tb_uart_cmd_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_valid_i = 1'b0;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b1;
  logic [AW-1:0] bus2ip_addr_o;
  logic [DW-1:0] bus2ip_data_o;
  logic          bus2ip_rd_ce_o;
  logic          bus2ip_wr_ce_o;
  logic [DW-1:0] ip2bus_data_i = '0;
  logic          busy_o;
  logic          timeout_o;

  always #5 clk = ~clk;

  uart_cmd_bridge #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data_i      (rx_data_i),
    .rx_valid_i     (rx_valid_i),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .bus2ip_addr_o  (bus2ip_addr_o),
    .bus2ip_data_o  (bus2ip_data_o),
    .bus2ip_rd_ce_o (bus2ip_rd_ce_o),
    .bus2ip_wr_ce_o (bus2ip_wr_ce_o),
    .ip2bus_data_i  (ip2bus_data_i),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  // Register stub: read data appears the cycle after the read strobe.
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h0020: return 16'hABCD;
      16'h0021: return 16'h5678;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus2ip_rd_ce_o) ip2bus_data_i <= mem_rd(bus2ip_addr_o);
  end

  logic tog_en = 1'b0;
  always @(posedge clk) begin
    if (tog_en) begin
      #1;
      tx_ready_i = ~tx_ready_i;
    end
  end

  logic [15:0] wr_a_q[$];
  logic [15:0] wr_d_q[$];
  logic [15:0] rd_a_q[$];
  logic [7:0]  tx_q[$];
  int          to_cnt = 0;
  int          ovl_cnt = 0;
  int          hold_err = 0;
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_byte = 8'h00;

  always @(negedge clk) begin
    if (bus2ip_wr_ce_o) begin
      wr_a_q.push_back(bus2ip_addr_o);
      wr_d_q.push_back(bus2ip_data_o);
    end
    if (bus2ip_rd_ce_o) rd_a_q.push_back(bus2ip_addr_o);
    if (bus2ip_wr_ce_o && bus2ip_rd_ce_o) ovl_cnt++;
    if (timeout_o) to_cnt++;
    if (hold_pend && rst_n && (!tx_valid_o || tx_data_o != hold_byte)) hold_err++;
    if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
    hold_pend = tx_valid_o && !tx_ready_i;
    hold_byte = tx_data_o;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bytes are spaced like a real UART so none land in the one-cycle WRITE state.
  task automatic send(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick(1);
    rx_valid_i = 1'b0;
    tick(2);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 300 && busy_o; k++) tick(1);
    check(name, 32'(busy_o), 32'd0);
  endtask

  typedef struct packed {
    logic [95:0] rx;
    logic [3:0]  nrx;
    logic [2:0]  nwr;
    logic [63:0] a;
    logic [63:0] d;
  } vec_t;

  vec_t vecs [5];

  task automatic apply_vec(input int i);
    vec_t v;
    int   n, nw, wb, tb;
    v  = vecs[i];
    n  = int'(v.nrx);
    nw = int'(v.nwr);
    wb = wr_a_q.size();
    tb = tx_q.size();
    for (int j = 0; j < n; j++) send(v.rx[8*(n-1-j) +: 8]);
    wait_idle($sformatf("v%0d_idle", i));
    tick(3);
    check($sformatf("v%0d_wr_count", i), 32'(wr_a_q.size() - wb), 32'(nw));
    for (int j = 0; j < nw; j++) begin
      check($sformatf("v%0d_wr%0d_addr", i, j), 32'(wr_a_q[wb+j]), 32'(v.a[16*(3-j) +: 16]));
      check($sformatf("v%0d_wr%0d_data", i, j), 32'(wr_d_q[wb+j]), 32'(v.d[16*(3-j) +: 16]));
    end
`ifdef UART_CMD_BRIDGE_ACK_EN
    check($sformatf("v%0d_ack_count", i), 32'(tx_q.size() - tb), 32'd1);
    check($sformatf("v%0d_ack_byte", i), 32'(tx_q[tb]), 32'hA5);
`else
    check($sformatf("v%0d_tx_count", i), 32'(tx_q.size() - tb), 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx"}, {23'd0, tx_valid_o, tx_data_o}, 32'd0);
    check({name, "_addr"}, 32'(bus2ip_addr_o), 32'd0);
    check({name, "_data"}, 32'(bus2ip_data_o), 32'd0);
    check({name, "_ctl"}, {28'd0, bus2ip_rd_ce_o, bus2ip_wr_ce_o, busy_o, timeout_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int wb, rb, tb, tob;

    vecs[0] = '{rx: 96'h80_00_10_12_34, nrx: 4'd5, nwr: 3'd1,
                a: 64'h0010_0000_0000_0000, d: 64'h1234_0000_0000_0000};
    vecs[1] = '{rx: 96'hC2_00_40_11_11_22_22_33_33, nrx: 4'd9, nwr: 3'd3,
                a: 64'h0040_0040_0040_0000, d: 64'h1111_2222_3333_0000};
    vecs[2] = '{rx: 96'h81_FF_FF_AA_AA_BB_BB, nrx: 4'd7, nwr: 3'd2,
                a: 64'hFFFF_0000_0000_0000, d: 64'hAAAA_BBBB_0000_0000};
    vecs[3] = '{rx: 96'h83_12_34_00_01_00_02_00_03_00_04, nrx: 4'd11, nwr: 3'd4,
                a: 64'h1234_1235_1236_1237, d: 64'h0001_0002_0003_0004};
    vecs[4] = '{rx: 96'h80_00_50_CA_FE, nrx: 4'd5, nwr: 3'd1,
                a: 64'h0050_0000_0000_0000, d: 64'hCAFE_0000_0000_0000};

    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 4; i++) apply_vec(i);

    // Gap shorter than the timeout must not abort.
    wb  = wr_a_q.size();
    tob = to_cnt;
    send(8'h80);
    send(8'h00);
    tick(12);
    send(8'h30);
    send(8'h11);
    send(8'h22);
    wait_idle("gap_idle");
    tick(3);
    check("gap_wr_count", 32'(wr_a_q.size() - wb), 32'd1);
    check("gap_wr_addr", 32'(wr_a_q[wb]), 32'h0030);
    check("gap_wr_data", 32'(wr_d_q[wb]), 32'h1122);
    check("gap_no_timeout", 32'(to_cnt - tob), 32'd0);

    // Stall after one address byte until the command is aborted.
    wb  = wr_a_q.size();
    tob = to_cnt;
    send(8'h80);
    send(8'h00);
    for (int k = 0; k < 100 && to_cnt == tob; k++) tick(1);
    tick(3);
    check("to_pulses", 32'(to_cnt - tob), 32'd1);
    check("to_no_wr", 32'(wr_a_q.size() - wb), 32'd0);
    check("to_busy", 32'(busy_o), 32'd0);
    apply_vec(4);

    // Two-word read with back-pressure; a stray byte during RDATA must be dropped.
    wb  = wr_a_q.size();
    rb  = rd_a_q.size();
    tb  = tx_q.size();
    tob = to_cnt;
    tog_en = 1'b1;
    send(8'h01);
    send(8'h00);
    send(8'h20);
    send(8'h80);
    wait_idle("rd_idle");
    tog_en = 1'b0;
    tick(2);
    tx_ready_i = 1'b1;
    tick(3);
    check("rd_count", 32'(rd_a_q.size() - rb), 32'd2);
    check("rd0_addr", 32'(rd_a_q[rb]), 32'h0020);
    check("rd1_addr", 32'(rd_a_q[rb+1]), 32'h0021);
    check("rd_tx_count", 32'(tx_q.size() - tb), 32'd4);
    check("rd_tx0", 32'(tx_q[tb]), 32'hAB);
    check("rd_tx1", 32'(tx_q[tb+1]), 32'hCD);
    check("rd_tx2", 32'(tx_q[tb+2]), 32'h56);
    check("rd_tx3", 32'(tx_q[tb+3]), 32'h78);
    check("rd_hold", 32'(hold_err), 32'd0);
    check("rd_no_wr", 32'(wr_a_q.size() - wb), 32'd0);
    check("rd_no_timeout", 32'(to_cnt - tob), 32'd0);

    // Reset while a read byte is waiting on the transmitter.
    rb = rd_a_q.size();
    tb = tx_q.size();
    tx_ready_i = 1'b0;
    send(8'h00);
    send(8'h00);
    send(8'h20);
    for (int k = 0; k < 50 && !tx_valid_o; k++) tick(1);
    check("rst_rdata_reached", 32'(tx_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("rst_after_busy", {30'd0, busy_o, tx_valid_o}, 32'd0);
    check("rst_rd_count", 32'(rd_a_q.size() - rb), 32'd1);
    check("rst_tx_count", 32'(tx_q.size() - tb), 32'd0);
    tx_ready_i = 1'b1;

    check("no_rd_wr_overlap", 32'(ovl_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 Parameter ADDR_W, default 16, bus address width in bits; SHALL be a multiple of 8 in the range 8..32.
REQ-002 Parameter DATA_W, default 16, bus data width in bits; SHALL be a multiple of 8 in the range 8..32.
REQ-003 Parameter TIMEOUT_CYC, default 100000, allowed idle clk cycles between command bytes.
REQ-004 clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rx_data_i  in  8  received byte from the UART receiver.
REQ-007 rx_valid_i  in  1  one-cycle strobe marking rx_data_i valid.
REQ-008 tx_data_o  out  8  byte to be transmitted by the UART.
REQ-009 tx_valid_o  out  1  tx_data_o is valid; byte is transferred on a cycle with tx_valid_o=1 and tx_ready_i=1.
REQ-010 tx_ready_i  in  1  UART transmitter can accept a byte.
REQ-011 bus2ip_addr_o  out  ADDR_W  register bus address.
REQ-012 bus2ip_data_o  out  DATA_W  register bus write data.
REQ-013 bus2ip_rd_ce_o  out  1  one-cycle read strobe.
REQ-014 bus2ip_wr_ce_o  out  1  one-cycle write strobe.
REQ-015 ip2bus_data_i  in  DATA_W  read data; valid the cycle after bus2ip_rd_ce_o.
REQ-016 busy_o  out  1  high whenever the state is not IDLE.
REQ-017 timeout_o  out  1  one-cycle pulse when a command is aborted by timeout.

Function
REQ-018 Command byte: bit7 = write (1) or read (0); bit6 = fixed address (1) or auto-increment (0); bits5:4 ignored; bits3:0 = word count N-1, giving N = 1..16.
REQ-019 After the command byte, ADDR_W/8 address bytes SHALL be received MSB first; for a write, N*DATA_W/8 data bytes SHALL follow, MSB first per word.
REQ-020 States SHALL be IDLE, ADDR, WDATA, WRITE, READ, RWAIT, RDATA, ACK.
REQ-021 State transitions SHALL be:
- IDLE->ADDR on any rx byte;
- ADDR->WDATA (write) or ADDR->READ (read) after the last address byte;
- WDATA->WRITE when a word is complete;
- WRITE->WDATA while words remain, else ->ACK or IDLE;
- READ->RWAIT->RDATA;
- RDATA->READ while words remain, else ->IDLE.
REQ-022 WRITE SHALL last exactly 1 cycle, asserting bus2ip_wr_ce_o with the current address and the assembled word.
REQ-023 READ SHALL assert bus2ip_rd_ce_o for 1 cycle; ip2bus_data_i SHALL be captured in RWAIT.
REQ-024 RDATA SHALL present the captured word MSB byte first on tx_data_o and hold each byte stable until it is accepted.
REQ-025 After each word, the address SHALL increment by 1 modulo 2^ADDR_W (all-ones wraps to 0) unless bit6 is set.
REQ-026 rx_valid_i SHALL be ignored in READ, RWAIT, RDATA, WRITE and ACK; those bytes are dropped.
REQ-027 In ADDR and WDATA, a gap of more than TIMEOUT_CYC cycles since the last rx byte SHALL abort to IDLE, pulse timeout_o, and issue no bus access for the partial word.
REQ-028 Words already written before a timeout SHALL remain written.
REQ-029 bus2ip_rd_ce_o and bus2ip_wr_ce_o SHALL never be high in the same cycle.

Reset
REQ-030 On rst_n=0, the block SHALL asynchronously enter IDLE and clear all counters.
REQ-031 Reset values SHALL be: tx_data_o=0x00, tx_valid_o=0, bus2ip_addr_o=0, bus2ip_data_o=0, bus2ip_rd_ce_o=0, bus2ip_wr_ce_o=0, busy_o=0, timeout_o=0.
REQ-032 Reset mid-operation SHALL drop the command and any pending tx byte without emitting a strobe.

Configuration
REQ-033 Macro UART_CMD_BRIDGE_ACK_EN: when defined, a write command that completes SHALL enter ACK and send byte 0xA5 via the tx handshake, then return to IDLE. When undefined, the ACK state is absent and the last WRITE returns directly to IDLE.

Verification (ADDR_W=16, DATA_W=16)
REQ-034 rx 0x80,0x00,0x10,0x12,0x34 -> exactly one wr_ce with addr 0x0010, data 0x1234.
REQ-035 Stub holds 0x20=0xABCD and 0x21=0x5678; rx 0x01,0x00,0x20 with tx_ready_i toggling 1/0 -> rd_ce at 0x0020 then 0x0021; tx bytes AB,CD,56,78 in order, each held while not ready.
REQ-036 rx 0xC2,0x00,0x40 then 3 words -> 3 wr_ce pulses, all at addr 0x0040.
REQ-037 rx 0x81,0xFF,0xFF then 2 words -> wr_ce at 0xFFFF, then at 0x0000.
REQ-038 rx 0x80,0x00 then idle TIMEOUT_CYC+1 cycles -> one timeout_o pulse, no wr_ce, busy_o=0; a following valid command executes normally.
REQ-039 Reset asserted mid-RDATA -> outputs at reset values immediately; with ACK_EN defined, the write in REQ-034 additionally yields tx 0xA5.
